seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder_pkg.sv | 25 ++
 rtl/seq_chunk_adder_if.sv | 33 +++
 rtl/seq_chunk_adder_chunk_adder.sv | 31 +++
 rtl/seq_chunk_adder.sv | 126 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_chunk_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared state encoding and sizing helpers for seq_chunk_adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/seq_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder_if
// Brief    : Request/result handshake bundle of the sequential chunk adder.
// Revision : 1.0
// ============================================================================
interface seq_chunk_adder_if #(
    parameter int WIDTH = 15
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface : seq_chunk_adder_if
`default_nettype wire

// File: rtl/seq_chunk_adder_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Brief    : Combinational ripple-carry adder over one CHUNK-bit slice.
// Revision : 1.0
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 5
) (
    input  wire logic [CHUNK-1:0] a,
    input  wire logic [CHUNK-1:0] b,
    input  wire logic             cin,
    output logic      [CHUNK-1:0] sum,
    output logic                  cout,
    output logic                  cmsb
);
    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[CHUNK];
    // Carry entering the top bit; the parent uses it for signed overflow.
    assign cmsb = w_carry[CHUNK-1];

endmodule : chunk_adder
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Brief    : Multi-cycle adder/subtractor processing CHUNK bits per clock.
// Revision : 1.0
// ============================================================================
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int CHUNK = 5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seq_chunk_adder_if.slave bus
);
    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int CW  = cnt_width(NCH);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("seq_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic [CHUNK-1:0]  w_a_cur;
    logic [CHUNK-1:0]  w_b_cur;
    logic [CHUNK-1:0]  w_sum_ch;
    logic              w_cout_ch;
    logic              w_cmsb_ch;
    logic [WIDTH-1:0]  w_sum_nxt;
    logic              w_last;
    logic              w_accept;

    assign w_last   = (r_cnt == CW'(NCH - 1));
    assign w_accept = (r_state == IDLE) && bus.in_valid;

    // Select the active slice and splice its sum into the running result.
    always_comb begin
        w_a_cur   = '0;
        w_b_cur   = '0;
        w_sum_nxt = r_sum;
        for (int i = 0; i < NCH; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_cur                        = r_a[i*CHUNK +: CHUNK];
                w_b_cur                        = r_b[i*CHUNK +: CHUNK];
                w_sum_nxt[i*CHUNK +: CHUNK]    = w_sum_ch;
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (w_a_cur),
        .b    (w_b_cur),
        .cin  (r_carry),
        .sum  (w_sum_ch),
        .cout (w_cout_ch),
        .cmsb (w_cmsb_ch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1, so b is inverted once at capture.
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_cout_ch;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_cout_ch;
                r_ovf  <= w_cmsb_ch ^ w_cout_ch;
                r_zero <= (w_sum_nxt == '0);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule : seq_chunk_adder
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder
// Brief    : Directed self-checking bench for CHUNK = 5, 15 and 1 variants.
// Revision : 1.0
// ============================================================================
module tb_seq_chunk_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(15)) bus5  ();
    seq_chunk_adder_if #(.WIDTH(15)) bus15 ();
    seq_chunk_adder_if #(.WIDTH(15)) bus1  ();

    seq_chunk_adder #(.WIDTH(15), .CHUNK(5))  u_dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
    seq_chunk_adder #(.WIDTH(15), .CHUNK(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15.slave));
    seq_chunk_adder #(.WIDTH(15), .CHUNK(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic [14:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } obs_t;

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        case (sel)
            0:       o = {bus5.in_ready,  bus5.out_valid,  bus5.sum,  bus5.cout,  bus5.ovf,  bus5.zero};
            1:       o = {bus15.in_ready, bus15.out_valid, bus15.sum, bus15.cout, bus15.ovf, bus15.zero};
            default: o = {bus1.in_ready,  bus1.out_valid,  bus1.sum,  bus1.cout,  bus1.ovf,  bus1.zero};
        endcase
        return o;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [14:0] a, input logic [14:0] b,
                          input logic cin, input logic sub);
        case (sel)
            0:       begin bus5.in_valid  = v; bus5.a  = a; bus5.b  = b; bus5.cin  = cin; bus5.sub  = sub; end
            1:       begin bus15.in_valid = v; bus15.a = a; bus15.b = b; bus15.cin = cin; bus15.sub = sub; end
            default: begin bus1.in_valid  = v; bus1.a  = a; bus1.b  = b; bus1.cin  = cin; bus1.sub  = sub; end
        endcase
    endtask

    task automatic set_ready(input int sel, input logic r);
        case (sel)
            0:       bus5.out_ready  = r;
            1:       bus15.out_ready = r;
            default: bus1.out_ready  = r;
        endcase
    endtask

    // Accept one operation, scramble the operand pins, wait for DONE.
    task automatic run_op(input int sel, input logic [14:0] a, input logic [14:0] b,
                          input logic cin, input logic sub, output int lat, output obs_t o);
        @(negedge clk);
        set_in(sel, 1'b1, a, b, cin, sub);
        @(posedge clk);
        @(negedge clk);
        set_in(sel, 1'b0, ~a, ~b, ~cin, ~sub);
        lat = 0;
        o   = get_obs(sel);
        while (!o.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            o = get_obs(sel);
        end
        if (!o.out_valid) lat = -1;
    endtask

    task automatic finish_op(input int sel);
        set_ready(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(sel, 1'b0);
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            o = get_obs(s);
            vectors++;
            if (o !== obs_t'({1'b1, 1'b0, 15'h0000, 3'b000})) begin
                miscompares++;
                $display("FAIL reset_state sel=%0d got=%h exp=%h", s, o, obs_t'({1'b1, 1'b0, 15'h0000, 3'b000}));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add(input int sel, input int nch);
        logic [14:0] va  [3];
        logic [14:0] vb  [3];
        logic [17:0] exp [3];
        obs_t o;
        int   lat;
        va[0] = 15'h0200; vb[0] = 15'h0200; exp[0] = {15'h0400, 3'b000};
        va[1] = 15'h7FFF; vb[1] = 15'h0001; exp[1] = {15'h0000, 3'b101};
        va[2] = 15'h3FFF; vb[2] = 15'h0001; exp[2] = {15'h4000, 3'b010};
        for (int v = 0; v < 3; v++) begin
            run_op(sel, va[v], vb[v], 1'b0, 1'b0, lat, o);
            vectors++;
            if (lat !== nch) begin
                miscompares++;
                $display("FAIL add_latency sel=%0d v=%0d got=%0d exp=%0d", sel, v, lat, nch);
            end
            vectors++;
            if ({o.sum, o.cout, o.ovf, o.zero} !== exp[v]) begin
                miscompares++;
                $display("FAIL add_result sel=%0d v=%0d got=%h exp=%h", sel, v, {o.sum, o.cout, o.ovf, o.zero}, exp[v]);
            end
            vectors++;
            if (o.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL add_in_ready_done sel=%0d v=%0d got=%b exp=0", sel, v, o.in_ready);
            end
            finish_op(sel);
            o = get_obs(sel);
            vectors++;
            if ({o.in_ready, o.out_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL add_return_idle sel=%0d v=%0d got=%b exp=10", sel, v, {o.in_ready, o.out_valid});
            end
        end
    endtask

    task automatic test_sub();
        obs_t o;
        int   lat;
        run_op(0, 15'h0005, 15'h0007, 1'b0, 1'b1, lat, o);
        vectors++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {15'h7FFE, 3'b000} || lat !== 3) begin
            miscompares++;
            $display("FAIL sub_5_minus_7 got=%h lat=%0d exp=%h lat=3", {o.sum, o.cout, o.ovf, o.zero}, lat, {15'h7FFE, 3'b000});
        end
        finish_op(0);
        run_op(0, 15'h0007, 15'h0005, 1'b1, 1'b1, lat, o);
        vectors++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {15'h0002, 3'b100} || lat !== 3) begin
            miscompares++;
            $display("FAIL sub_7_minus_5 got=%h lat=%0d exp=%h lat=3", {o.sum, o.cout, o.ovf, o.zero}, lat, {15'h0002, 3'b100});
        end
        finish_op(0);
    endtask

    task automatic test_hold_done();
        obs_t o;
        int   lat;
        run_op(0, 15'h0123, 15'h0456, 1'b1, 1'b0, lat, o);
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1'b1, 15'(k * 15'h1111), 15'(~(k * 15'h0F0F)), k[0], k[1]);
            @(posedge clk);
            @(negedge clk);
            o = get_obs(0);
            vectors++;
            if (o !== obs_t'({1'b0, 1'b1, 15'h057A, 3'b000})) begin
                miscompares++;
                $display("FAIL hold_done cyc=%0d got=%h exp=%h", k, o, obs_t'({1'b0, 1'b1, 15'h057A, 3'b000}));
            end
        end
        set_in(0, 1'b1, 15'h0001, 15'h0002, 1'b0, 1'b0);
        set_ready(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(0, 1'b0);
        o = get_obs(0);
        vectors++;
        if ({o.in_ready, o.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL hold_release_idle got=%b exp=10", {o.in_ready, o.out_valid});
        end
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 15'h0000, 15'h0000, 1'b0, 1'b0);
        o = get_obs(0);
        vectors++;
        if (o.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_next_accept got=%b exp=0", o.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = get_obs(0);
        vectors++;
        if (o.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_next_early_valid got=%b exp=0", o.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        o = get_obs(0);
        vectors++;
        if ({o.out_valid, o.sum, o.cout, o.ovf, o.zero} !== {1'b1, 15'h0003, 3'b000}) begin
            miscompares++;
            $display("FAIL hold_next_result got=%h exp=%h", {o.out_valid, o.sum, o.cout, o.ovf, o.zero}, {1'b1, 15'h0003, 3'b000});
        end
        finish_op(0);
    endtask

    task automatic test_reset_mid_run();
        obs_t o;
        int   lat;
        bit   seen_valid;
        @(negedge clk);
        set_in(0, 1'b1, 15'h0011, 15'h0022, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 15'h0000, 15'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        o = get_obs(0);
        vectors++;
        if ({o.in_ready, o.out_valid, o.sum} !== {2'b00, 15'h0013}) begin
            miscompares++;
            $display("FAIL midrun_partial got=%h exp=%h", {o.in_ready, o.out_valid, o.sum}, {2'b00, 15'h0013});
        end
        #1 rst_n = 1'b0;
        #1;
        o = get_obs(0);
        vectors++;
        if (o !== obs_t'({1'b1, 1'b0, 15'h0000, 3'b000})) begin
            miscompares++;
            $display("FAIL midrun_async_clear got=%h exp=%h", o, obs_t'({1'b1, 1'b0, 15'h0000, 3'b000}));
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (get_obs(0).out_valid) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_aborted_valid got=%b exp=0", seen_valid);
        end
        run_op(0, 15'h0200, 15'h0200, 1'b0, 1'b0, lat, o);
        vectors++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {15'h0400, 3'b000} || lat !== 3) begin
            miscompares++;
            $display("FAIL midrun_after_reset got=%h lat=%0d exp=%h lat=3", {o.sum, o.cout, o.ovf, o.zero}, lat, {15'h0400, 3'b000});
        end
        finish_op(0);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            set_in(s, 1'b0, 15'h0000, 15'h0000, 1'b0, 1'b0);
            set_ready(s, 1'b0);
        end
        test_reset();
        test_add(0, 3);
        test_add(1, 1);
        test_add(2, 15);
        test_sub();
        test_hold_done();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_chunk_adder
`default_nettype wire
